// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a reused 16-bit adder.
// Latency: product valid 16 edges after the accepting edge; one edge to return to idle.
// Backpressure: in_ready only in IDLE; product/ovf held in DONE until out_ready.

// 16-bit adder with carry-out, shared by every multiply step
module mul16_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum,
  output logic        o_c
);
  assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, i_b};
endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_mcand;
  logic [15:0] r_hi;
  logic [15:0] r_lo;
  logic [3:0]  r_count;
  logic        r_out_valid;
  logic        r_ovf;

  logic [15:0] w_addend;
  logic [15:0] w_sum;
  logic        w_c;

  // Partial-product high half plus the multiplicand gated by the current multiplier bit
  assign w_addend = r_lo[0] ? r_mcand : 16'h0000;

  mul16_adder u_adder (
    .i_a   (r_hi),
    .i_b   (w_addend),
    .o_sum (w_sum),
    .o_c   (w_c)
  );

  // Reset is folded in so a reset cycle never advertises readiness
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign product   = {r_hi, r_lo};
  assign ovf       = r_ovf;

  // Control FSM and datapath: capture, 16 shift-add steps, then hold until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mcand     <= 16'h0000;
      r_hi        <= 16'h0000;
      r_lo        <= 16'h0000;
      r_count     <= 4'd0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand <= a;
            r_lo    <= b;
            r_hi    <= 16'h0000;
            r_count <= 4'd0;
            r_ovf   <= 1'b0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Carry lands in hi[15] so the full 33-bit sum survives the shift
          {r_hi, r_lo} <= {w_c, w_sum, r_lo[15:1]};
          r_count      <= r_count + 4'd1;
          if (r_count == 4'd15) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_ovf       <= w_c | (|w_sum[15:1]);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: random and directed operands against a*b.
// Latency, spacing and hold-under-stall are checked by a free-running monitor.
// out_ready is either forced by the stimulus or randomly stalled.
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] product;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        rnd_mode    = 1'b0;
  logic        ready_force = 1'b1;

  logic [32:0] exp_q[$];
  int          acc_q[$];

  mul16_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // out_ready driver: random stalls or the value chosen by the stimulus
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: latency on each rising out_valid, rise spacing, and product/ovf every valid cycle
  initial begin
    logic prev_vld;
    logic have_rise;
    int   last_rise;
    int   acc;
    prev_vld  = 1'b0;
    have_rise = 1'b0;
    last_rise = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_vld = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_vld) begin
            if (acc_q.size() == 0) begin
              chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
              acc = acc_q.pop_front();
              chk("latency", 32'(cyc - acc), 32'd16);
            end
            if (have_rise) chk("spacing_ge_18", {31'd0, (cyc - last_rise) >= 18}, 32'd1);
            last_rise = cyc;
            have_rise = 1'b1;
          end
          if (exp_q.size() != 0) begin
            chk("product", product, exp_q[0][31:0]);
            chk("ovf", {31'd0, ovf}, {31'd0, exp_q[0][32]});
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_vld = out_valid;
      end
    end
  end

  // Present operands until accepted; reference result is plain a*b
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
    logic [31:0] p;
    int t;
    p = {16'h0, ia} * {16'h0, ib};
    in_valid = 1'b1;
    a = ia;
    b = ib;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back({p[31:16] != 16'h0, p});
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && t < 2000) begin
      t++;
      @(negedge clk);
    end
    if (exp_q.size() != 0 || acc_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset held with in_valid asserted
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h5555;
    b = 16'h3333;
    repeat (2) begin
      @(negedge clk);
      chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Basic and carry-stress operands
    issue(16'd3, 16'd5);           drain();
    issue(16'hFFFF, 16'hFFFF);     drain();
    issue(16'h8000, 16'h0002);     drain();
    issue(16'h0000, 16'hFFFF);     drain();

    // Backpressure: hold result, ignore operand pulses
    ready_force = 1'b0;
    @(posedge clk);
    #3;
    issue(16'h00FF, 16'h0101);
    t = 0;
    while (!out_valid && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("bp_reached_done", {31'd0, out_valid}, 32'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = 16'd1;
      b = 16'd1;
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    chk("bp_product_held", product, 32'h0000FFFF);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_out_valid_cleared", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue(16'd1, 16'd1);           drain();

    // Reset in the middle of an operation
    issue(16'h1234, 16'h0002);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_product", product, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue(16'd7, 16'd6);           drain();

    // Random operands with random consumer stalls
    rnd_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'hFFFF;
        1: rb = 16'h0000;
        2: rb = 16'hFFFF;
        default: ;
      endcase
      issue(ra, rb);
    end
    drain();
    rnd_mode = 1'b0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Sequential 16x16 unsigned shift-and-add multiplier producing a full 32-bit product.
- Sits directly upstream of the 16-bit ripple-carry adder and consumes its output. Each cycle it drives the adder with the partial-product high half and the multiplicand, then registers the sum and carry-out.
- One adder instance is reused for 16 iterations. Operands arrive over a valid/ready handshake and the result leaves over one.

Parameters:
- None. Width is fixed at 16 to match the 16-bit adder.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  16  multiplicand (unsigned)
- b  input  16  multiplier (unsigned)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  32  a*b, {hi, lo}
- ovf  output  1  product does not fit in 16 bits (hi != 0)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it is sampled only on the rising edge of clk.
- Registers:
  - mcand[15:0]
  - hi[15:0]
  - lo[15:0]
  - count[3:0]
  - state in {IDLE, BUSY, DONE}
- Reset values: state=IDLE, hi=lo=mcand=0, count=0. This gives out_valid=0, product=0 and ovf=0.
- in_ready = (state==IDLE) && !rst. In the first cycle after rst deasserts, in_ready=1.
- IDLE:
  - On in_valid && in_ready at an edge: mcand<=a, lo<=b, hi<=0, count<=0, state<=BUSY.
  - Otherwise hold.
- BUSY, one step per edge:
  - Adder inputs are hi and (lo[0] ? mcand : 16'h0). It returns sum[15:0] and carry c.
  - Update {hi, lo} <= {c, sum, lo[15:1]}, i.e. the 33-bit value shifted right by 1.
  - count<=count+1. If count==15 then state<=DONE.
  - Exactly 16 steps. No early termination, even when b=0.
- Latency: out_valid rises exactly 16 edges after the accepting edge. The accept edge is E0, steps occur at E1..E16, and state=DONE after E16.
- DONE:
  - out_valid=1; product={hi,lo}; ovf=|hi.
  - product and ovf are held stable while out_ready=0, for any number of cycles.
  - On out_valid && out_ready at an edge: state<=IDLE. hi/lo are retained; product is don't-care while out_valid=0.
- in_valid is ignored in BUSY and DONE. No operand capture is allowed there, because in_ready=0.
- No same-cycle turnaround: DONE->IDLE costs one edge, and the next accept is possible at the following edge. Minimum period is 18 cycles per operation.
- Reset mid-operation in BUSY or DONE: at that edge all registers return to reset values and the in-flight result is discarded. out_valid=0 from the next cycle.
- rst has priority over every handshake in the same cycle.
- Arithmetic:
  - Unsigned only. The carry out of the adder at each step is captured into hi[15] after the shift, so no bit is lost.
  - The maximum product 0xFFFE0001 must be exact.

Test Plan:
- Reset: hold rst=1 for 2 edges with in_valid=1 -> in_ready=0 during rst; after release out_valid=0, product=0, ovf=0, in_ready=1.
- Basic: a=3, b=5 accepted at edge E0 -> out_valid=0 through E15; at E16 out_valid=1, product=0x0000000F, ovf=0.
- Carry stress: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, ovf=1. Then a=0x8000, b=2 -> product=0x00010000, ovf=1. Then a=0, b=0xFFFF -> product=0, out_valid still at E16.
- Backpressure: a=0x00FF, b=0x0101, out_ready=0 for 10 cycles after DONE -> product=0x0000FFFF held stable, ovf=0. in_valid pulses with a=1, b=1 are ignored (in_ready=0). Raise out_ready -> IDLE next edge, in_ready=1; next op a=1, b=1 yields product=1.
- Reset mid-op: accept a=0x1234, b=0x0002, assert rst for one edge after step 8 -> next cycle state IDLE, out_valid=0, product=0, in_ready=1. Then a=7, b=6 -> product=42 after 16 edges.
- Randomised: 200 random a/b pairs with random out_ready stalls -> every product matches a*b, ovf matches (a*b)>>16 != 0, and out_valid spacing is always >=18 cycles.
